// File: rtl/i2s_rx_tdm.sv
// I2S / left-justified TDM serial audio receiver, fully in the clk domain.
// bck/lrck/din are oversampled; words are delivered per slot with channel index.
module i2s_rx_tdm #(
   parameter int WORD_SIZE   = 24,
   parameter int SLOT_SIZE   = 32,
   parameter int NUM_CH      = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic                 bck,
   input  logic                 lrck,
   input  logic                 din,
   output logic [WORD_SIZE-1:0] dout,
   output logic [2:0]           dout_ch,
   output logic                 dout_valid,
   output logic                 sync_lock,
   output logic                 frame_err
);

   localparam int         FRAME     = NUM_CH * SLOT_SIZE;
   localparam logic [5:0] WORD_LAST = 6'(WORD_SIZE - 1);
   localparam logic [5:0] SLOT_LAST = 6'(SLOT_SIZE - 1);
   localparam logic [3:0] NCH       = 4'(NUM_CH);
   localparam logic [9:0] FRAME_LEN = 10'(FRAME);
   localparam logic [9:0] FRAME_OVR = 10'(FRAME + 1);

   logic [SYNC_STAGES-1:0] bck_sync, lrck_sync, din_sync;
   logic                   bck_s, lrck_s, din_s;
   logic                   bck_prev, lrck_q;
   logic                   rise, lrck_fall;
   logic [9:0]             fcnt, fcnt_inc, nxt_fcnt;
   logic [5:0]             pos, nxt_pos, cap_pos;
   logic [3:0]             slot, nxt_slot, cap_slot;
   logic                   cap_en, cap_bit, cap_last;
   logic                   nxt_lock, err;
   logic [WORD_SIZE-1:0]   shreg;
   logic                   word_done;
   logic [2:0]             word_ch;

   assign bck_s     = bck_sync[SYNC_STAGES-1];
   assign lrck_s    = lrck_sync[SYNC_STAGES-1];
   assign din_s     = din_sync[SYNC_STAGES-1];
   assign rise      = bck_s & ~bck_prev;
   assign lrck_fall = lrck_q & ~lrck_s;
   assign fcnt_inc  = fcnt + 10'd1;

   // In I2S mode the rise that sees the lrck fall still carries the previous
   // frame's last bit; in left-justified mode it is bit 0 of the new frame.
   always_comb begin
      cap_en   = 1'b0;
      cap_pos  = pos;
      cap_slot = slot;
      nxt_pos  = pos;
      nxt_slot = slot;
      nxt_fcnt = fcnt;
      nxt_lock = sync_lock;
      err      = 1'b0;
      if (rise) begin
         if (lrck_fall) begin
            nxt_fcnt = '0;
            nxt_lock = 1'b1;
            nxt_slot = '0;
            err      = sync_lock && (fcnt_inc != FRAME_LEN);
            if (mode) begin
               cap_en   = 1'b1;
               cap_pos  = '0;
               cap_slot = '0;
               nxt_pos  = 6'd1;
            end else begin
               cap_en  = sync_lock;
               nxt_pos = '0;
            end
         end else if (sync_lock) begin
            if (fcnt_inc == FRAME_OVR) begin
               err      = 1'b1;
               nxt_lock = 1'b0;
               nxt_fcnt = '0;
            end else begin
               nxt_fcnt = fcnt_inc;
               cap_en   = 1'b1;
               if (pos == SLOT_LAST) begin
                  nxt_pos = '0;
                  if (slot != NCH)
                     nxt_slot = slot + 4'd1;
               end else begin
                  nxt_pos = pos + 6'd1;
               end
            end
         end
      end
   end

   assign cap_bit  = cap_en && (cap_slot < NCH) && (cap_pos <= WORD_LAST);
   assign cap_last = cap_bit && (cap_pos == WORD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bck_sync   <= '0;
         lrck_sync  <= '0;
         din_sync   <= '0;
         bck_prev   <= 1'b0;
         lrck_q     <= 1'b0;
         fcnt       <= '0;
         pos        <= '0;
         slot       <= '0;
         sync_lock  <= 1'b0;
         frame_err  <= 1'b0;
         shreg      <= '0;
         word_done  <= 1'b0;
         word_ch    <= '0;
         dout       <= '0;
         dout_ch    <= '0;
         dout_valid <= 1'b0;
      end else begin
         bck_sync   <= {bck_sync[SYNC_STAGES-2:0], bck};
         lrck_sync  <= {lrck_sync[SYNC_STAGES-2:0], lrck};
         din_sync   <= {din_sync[SYNC_STAGES-2:0], din};
         bck_prev   <= bck_s;
         if (rise)
            lrck_q <= lrck_s;
         fcnt       <= nxt_fcnt;
         pos        <= nxt_pos;
         slot       <= nxt_slot;
         sync_lock  <= nxt_lock;
         frame_err  <= err;
         if (cap_bit)
            shreg <= {shreg[WORD_SIZE-2:0], din_s};
         word_done  <= cap_last;
         if (cap_last)
            word_ch <= cap_slot[2:0];
         dout_valid <= word_done;
         if (word_done) begin
            dout    <= shreg;
            dout_ch <= word_ch;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx_tdm.sv
// Randomized bench for i2s_rx_tdm: a stereo I2S instance and an 8-slot LJ instance
// share the serial pins; expected words come from a frame-level model.
module tb_i2s_rx_tdm;

   logic        clk = 1'b0;
   logic        rst_n, mode, bck, lrck, din;
   logic [23:0] dout_a;
   logic [15:0] dout_b;
   logic [2:0]  ch_a, ch_b;
   logic        va, vb, lk_a, lk_b, fe_a, fe_b;

   typedef struct {
      logic [2:0]  ch;
      logic [23:0] w;
   } exp_t;

   exp_t        exp_q[$];
   logic [23:0] fw[8];
   int          n_checks = 0;
   int          n_errors = 0;
   int          nerr = 0;
   bit          act = 1'b0;
   bit          carry = 1'b0;

   logic        m_v, m_fe;
   logic [23:0] m_d;
   logic [2:0]  m_c;
   exp_t        m_e;

   always #5 clk = ~clk;

   i2s_rx_tdm dut_a (
      .clk(clk), .rst_n(rst_n), .mode(mode), .bck(bck), .lrck(lrck), .din(din),
      .dout(dout_a), .dout_ch(ch_a), .dout_valid(va), .sync_lock(lk_a), .frame_err(fe_a)
   );

   i2s_rx_tdm #(.WORD_SIZE(16), .SLOT_SIZE(32), .NUM_CH(8), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .mode(mode), .bck(bck), .lrck(lrck), .din(din),
      .dout(dout_b), .dout_ch(ch_b), .dout_valid(vb), .sync_lock(lk_b), .frame_err(fe_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         m_v  = act ? vb : va;
         m_d  = act ? {8'h00, dout_b} : dout_a;
         m_c  = act ? ch_b : ch_a;
         m_fe = act ? fe_b : fe_a;
         if (m_v) begin
            if (exp_q.size() == 0) begin
               check("valid_unexpected", {31'd0, m_v}, 32'd0);
            end else begin
               m_e = exp_q.pop_front();
               check("dout_ch", {29'd0, m_c}, {29'd0, m_e.ch});
               check("dout", {8'd0, m_d}, {8'd0, m_e.w});
            end
         end
         if (m_fe)
            nerr++;
      end
   end

   // One bck period; lj=0 delays the data by one bck relative to lrck.
   task automatic send_rise(input logic l, input logic b, input bit lj);
      bck  = 1'b0;
      lrck = l;
      mode = lj;
      din  = lj ? b : carry;
      carry = b;
      #40;
      bck = 1'b1;
      #40;
   endtask

   task automatic idle_rises(input int n, input bit lj);
      for (int i = 0; i < n; i++)
         send_rise(1'b1, 1'($urandom_range(0, 1)), lj);
   endtask

   // Sends the first `cut` rises of a frame of `len` rises; a word is expected
   // when the rise carrying its last bit is sent (for I2S at len, the next frame's first rise).
   task automatic send_frame(input int nch, input int slot, input int wsz,
                             input int len, input int cut, input bit lj);
      int   rl, lim, s, p;
      logic b;
      logic [23:0] mask;
      exp_t e;
      mask = 24'((32'd1 << wsz) - 1);
      lim  = (cut == len) ? len + (lj ? 0 : 1) : cut;
      for (int k = 0; k < nch; k++) begin
         rl = k * slot + wsz - 1 + (lj ? 0 : 1);
         if (rl < lim) begin
            e.ch = 3'(k);
            e.w  = fw[k] & mask;
            exp_q.push_back(e);
         end
      end
      for (int r = 0; r < cut; r++) begin
         s = r / slot;
         p = r % slot;
         if (s < nch && p < wsz)
            b = fw[s][wsz-1-p];
         else
            b = 1'($urandom_range(0, 1));
         send_rise((r < len / 2) ? 1'b0 : 1'b1, b, lj);
      end
   endtask

   task automatic rand_words(input int nch);
      for (int k = 0; k < nch; k++)
         fw[k] = 24'($urandom);
   endtask

   task automatic do_reset(input bit lj);
      rst_n = 1'b0;
      bck   = 1'b0;
      lrck  = 1'b1;
      #50;
      rst_n = 1'b1;
      #20;
      nerr = 0;
      idle_rises(4, lj);
   endtask

   initial begin
      rst_n = 1'b0;
      mode  = 1'b0;
      bck   = 1'b0;
      lrck  = 1'b1;
      din   = 1'b0;
      #50;
      check("rst_dout", {8'd0, dout_a}, 32'd0);
      check("rst_ch", {29'd0, ch_a}, 32'd0);
      check("rst_valid", {31'd0, va}, 32'd0);
      check("rst_lock", {31'd0, lk_a}, 32'd0);
      check("rst_ferr", {31'd0, fe_a}, 32'd0);
      rst_n = 1'b1;
      #20;

      // idle: lrck constant high beyond a frame length, never locked
      idle_rises(70, 1'b0);
      #100;
      check("idle_lock", {31'd0, lk_a}, 32'd0);
      check("idle_ferr_count", nerr, 0);
      check("idle_dout", {8'd0, dout_a}, 32'd0);

      // I2S stereo: fixed words, then random ones
      fw[0] = 24'hA5A5A5;
      fw[1] = 24'h123456;
      for (int f = 0; f < 3; f++)
         send_frame(2, 32, 24, 64, 64, 1'b0);
      check("i2s_lock", {31'd0, lk_a}, 32'd1);
      for (int f = 0; f < 3; f++) begin
         rand_words(2);
         send_frame(2, 32, 24, 64, 64, 1'b0);
      end
      idle_rises(1, 1'b0);
      #400;
      check("i2s_drained", exp_q.size(), 0);
      check("i2s_ferr_count", nerr, 0);

      // short frame of 60 bck
      do_reset(1'b0);
      rand_words(2);
      send_frame(2, 32, 24, 64, 64, 1'b0);
      rand_words(2);
      send_frame(2, 32, 24, 60, 60, 1'b0);
      for (int f = 0; f < 2; f++) begin
         rand_words(2);
         send_frame(2, 32, 24, 64, 64, 1'b0);
      end
      idle_rises(1, 1'b0);
      #400;
      check("short_drained", exp_q.size(), 0);
      check("short_ferr_count", nerr, 1);
      check("short_lock", {31'd0, lk_a}, 32'd1);

      // lost frame sync: lrck high for two frames
      do_reset(1'b0);
      for (int f = 0; f < 2; f++) begin
         rand_words(2);
         send_frame(2, 32, 24, 64, 64, 1'b0);
      end
      idle_rises(128, 1'b0);
      #400;
      check("lost_lock", {31'd0, lk_a}, 32'd0);
      check("lost_ferr_count", nerr, 1);
      check("lost_drained", exp_q.size(), 0);
      for (int f = 0; f < 2; f++) begin
         rand_words(2);
         send_frame(2, 32, 24, 64, 64, 1'b0);
      end
      idle_rises(1, 1'b0);
      #400;
      check("relock_lock", {31'd0, lk_a}, 32'd1);
      check("relock_drained", exp_q.size(), 0);
      check("relock_ferr_count", nerr, 1);

      // async reset at bit 10 of slot 1
      do_reset(1'b0);
      rand_words(2);
      send_frame(2, 32, 24, 64, 64, 1'b0);
      fw[0] = 24'hA5A5A5;
      fw[1] = 24'h5A5A5A;
      send_frame(2, 32, 24, 64, 43, 1'b0);
      #100;
      check("pre_rst_dout", {8'd0, dout_a}, 32'h00A5A5A5);
      rst_n = 1'b0;
      #1;
      check("mid_rst_dout", {8'd0, dout_a}, 32'd0);
      check("mid_rst_ch", {29'd0, ch_a}, 32'd0);
      check("mid_rst_lock", {31'd0, lk_a}, 32'd0);
      bck = 1'b0;
      #49;
      rst_n = 1'b1;
      #20;
      idle_rises(20, 1'b0);
      #200;
      check("post_rst_lock", {31'd0, lk_a}, 32'd0);
      check("post_rst_drained", exp_q.size(), 0);
      for (int f = 0; f < 2; f++) begin
         rand_words(2);
         send_frame(2, 32, 24, 64, 64, 1'b0);
      end
      idle_rises(1, 1'b0);
      #400;
      check("post_rst_words", exp_q.size(), 0);
      check("post_rst_lock2", {31'd0, lk_a}, 32'd1);

      // left-justified 8-slot TDM, 16-bit words
      act = 1'b1;
      do_reset(1'b1);
      for (int k = 0; k < 8; k++)
         fw[k] = 24'h1000 + 24'(k);
      send_frame(8, 32, 16, 256, 256, 1'b1);
      rand_words(8);
      send_frame(8, 32, 16, 256, 256, 1'b1);
      idle_rises(1, 1'b1);
      #400;
      check("tdm_drained", exp_q.size(), 0);
      check("tdm_ferr_count", nerr, 0);
      check("tdm_lock", {31'd0, lk_b}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
